serial_sub: RTL and testbench

- Bit-serial N-bit subtractor: computes d = a - b - bi, one bit per clock, LSB first.
- Built around a single 1-bit full-subtractor cell (difference/borrow), the borrow-chain counterpart of the 1-bit full adder.
- Serves as the low-area subtract path in the datapath lab designs.
- Uses a start/busy/done handshake with a registered result.

---
 rtl/serial_sub.sv | 119 +++++++++++
 tb/tb_serial_sub.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bi, one bit per clock, LSB first.
// A single full-subtractor cell is reused every cycle; results are registered at completion.

module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// state  | meaning
// IDLE   | waiting for start; operands are captured on the accepting edge
// RUN    | one bit processed per edge, LSB first
// DONE   | result registered; done high for this single cycle
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] rr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic db;
  logic brw_nxt;

  serial_sub_cell u_cell (
    .x    (ar[0]),
    .y    (br[0]),
    .bin  (brw),
    .diff (db),
    .bout (brw_nxt)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      ar    <= '0;
      br    <= '0;
      rr    <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ar    <= a;
            br    <= b;
            brw   <= bi;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          ar  <= ar >> 1;
          br  <= br >> 1;
          rr  <= {db, rr[WIDTH-1:1]};
          brw <= brw_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // brw here is the borrow into the MSB, brw_nxt the borrow out of it
            d     <= {db, rr[WIDTH-1:1]};
            bo    <= brw_nxt;
            ov    <= brw ^ brw_nxt;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: cycle-level reference model plus directed literal checks.

module tb_serial_sub;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         clrn  = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bi    = 1'b0;
  logic         busy, done, bo, ov;
  logic [W-1:0] d;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ov    (ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integer math: {d, bo, ov}
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int u;
    int s;
    logic [W-1:0] dd;
    logic bb, oo;
    u  = int'(x) - int'(y) - int'(c);
    s  = int'($signed(x)) - int'($signed(y)) - int'(c);
    dd = u[W-1:0];
    bb = (u < 0);
    oo = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return {dd, bb, oo};
  endfunction

  // Model: a run lasts W+1 busy cycles, the last of which is the done cycle
  int           m_left = 0;
  logic [W-1:0] m_d = '0, p_d = '0;
  logic         m_bo = 1'b0, m_ov = 1'b0, p_bo = 1'b0, p_ov = 1'b0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_left = 0;
      m_d    = '0;
      m_bo   = 1'b0;
      m_ov   = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        {p_d, p_bo, p_ov} = ref_sub(a, b, bi);
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_d  = p_d;
        m_bo = p_bo;
        m_ov = p_ov;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(busy), 32'(m_left > 0));
      check("cyc_done", 32'(done), 32'(m_left == 1));
      check("cyc_d",    32'(d),    32'(m_d));
      check("cyc_bo",   32'(bo),   32'(m_bo));
      check("cyc_ov",   32'(ov),   32'(m_ov));
    end
  end

  // Counts negedges until done is seen; timeout is a failed comparison
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tbi, input logic [W-1:0] ed, input logic ebo,
                       input logic eov);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_v; bi = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check({nm, "_lat"}, 32'(lat), 32'(W + 1));
    check({nm, "_d"},   32'(d),   32'(ed));
    check({nm, "_bo"},  32'(bo),  32'(ebo));
    check({nm, "_ov"},  32'(ov),  32'(eov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [W-1:0] va [5] = '{8'h5A, 8'h10, 8'h80, 8'h00, 8'h7F};
  logic [W-1:0] vb [5] = '{8'h23, 8'h20, 8'h01, 8'h00, 8'hFF};
  logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] vd [5] = '{8'h37, 8'hF0, 8'h7F, 8'hFF, 8'h80};
  logic         vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic         vov[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int lat;
    int ndone;

    // Reset with start high and arbitrary operands
    #2;
    start = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    bi = 1'b1;
    clrn = 1'b0;
    cmp_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_d",    32'(d),    32'(0));
    end
    check("rst_done", 32'(done), 32'(0));
    check("rst_bo",   32'(bo),   32'(0));
    check("rst_ov",   32'(ov),   32'(0));
    start = 1'b0;
    bi = 1'b0;
    #2 clrn = 1'b1;

    // Basic subtract, corners
    do_op("basic", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    do_op("c1",    8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    do_op("c2",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op("c3",    8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("c4",    8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Ignored start: first result 0x37, second run 0x10-0x20
    do_op("ign_a", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_hold_d", 32'(d), 32'(8'h37));
    check("ign_busy",   32'(busy), 32'(1));
    wait_done(lat);
    check("ign_d",  32'(d),  32'(8'hF0));
    check("ign_bo", 32'(bo), 32'(1));
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_extra_done", 32'(ndone), 32'(0));
    check("ign_final_d",    32'(d),     32'(8'hF0));

    // Back-to-back with start held high
    @(posedge clk); #1;
    a = va[0]; b = vb[0]; bi = vc[0]; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_done(lat);
      check($sformatf("b2b%0d_period", i), 32'(lat), 32'(W + 2));
      check($sformatf("b2b%0d_d", i),  32'(d),  32'(vd[i]));
      check($sformatf("b2b%0d_bo", i), 32'(bo), 32'(vbo[i]));
      check($sformatf("b2b%0d_ov", i), 32'(ov), 32'(vov[i]));
      if (i < 4) begin
        a = va[i+1]; b = vb[i+1]; bi = vc[i+1];
      end else begin
        start = 1'b0;
      end
    end
    bi = 1'b0;
    repeat (3) @(posedge clk);

    // Reset mid-run at RUN cycle 4
    #1;
    a = 8'h5A; b = 8'h23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'(0));
    check("mid_done", 32'(done), 32'(0));
    check("mid_d",    32'(d),    32'(0));
    check("mid_bo",   32'(bo),   32'(0));
    check("mid_ov",   32'(ov),   32'(0));
    repeat (2) @(posedge clk);
    #2 clrn = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_no_done", 32'(ndone), 32'(0));
    do_op("post_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
